// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial 4-bit subtractor computing d = a - b - b_in, one
//               bit per clock, exposing the full borrow chain in b_out.
//               Optional signed-overflow output enabled by macro SUB_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       b_in,
    output logic [3:0] d,
    output logic [3:0] b_out,
`ifdef SUB_OVF_EN
    output logic       ovf,
`endif
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] C_LAST  = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_bin;
    logic [1:0] r_idx;
    logic [3:0] r_d;
    logic [3:0] r_bout;
    logic       w_bor;
    logic       w_dbit;
    logic       w_borbit;
    logic [3:0] w_bout_next;
    logic [1:0] w_idx_prev;

    assign w_idx_prev = r_idx - 2'd1;

    // Single-bit full subtractor on the bit currently selected by r_idx
    always_comb begin
        w_bor       = (r_idx == 2'd0) ? r_bin : r_bout[w_idx_prev];
        w_dbit      = r_a[r_idx] ^ r_b[r_idx] ^ w_bor;
        w_borbit    = (~r_a[r_idx] & r_b[r_idx]) |
                      (~(r_a[r_idx] ^ r_b[r_idx]) & w_bor);
        w_bout_next = r_bout;
        w_bout_next[r_idx] = w_borbit;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start is only looked at while idle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SHIFT;
            S_SHIFT: if (r_idx == C_LAST) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        busy = (r_state == S_SHIFT) || (r_state == S_DONE);
        done = (r_state == S_DONE);
    end

    // Operand capture and per-bit result update
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a    <= 4'd0;
            r_b    <= 4'd0;
            r_bin  <= 1'b0;
            r_idx  <= 2'd0;
            r_d    <= 4'd0;
            r_bout <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_bin  <= b_in;
                        r_idx  <= 2'd0;
                        r_d    <= 4'd0;
                        r_bout <= 4'd0;
                    end
                end
                S_SHIFT: begin
                    r_d[r_idx] <= w_dbit;
                    r_bout     <= w_bout_next;
                    r_idx      <= r_idx + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SUB_OVF_EN
    logic r_ovf;

    // Signed overflow: borrow into MSB differs from borrow out of MSB
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_SHIFT && r_idx == C_LAST) begin
            r_ovf <= w_bout_next[3] ^ w_bout_next[2];
        end
    end

    assign ovf = r_ovf;
`endif

    assign d     = r_d;
    assign b_out = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       b_in;
    logic [3:0] d;
    logic [3:0] b_out;
    logic       busy;
    logic       done;
`ifdef SUB_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .d     (d),
        .b_out (b_out),
`ifdef SUB_OVF_EN
        .ovf   (ovf),
`endif
        .busy  (busy),
        .done  (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: plain integer arithmetic
    function automatic logic [3:0] ref_d(input int ai, input int bi, input int ci);
        int r;
        r = ai - bi - ci;
        return 4'((r + 32) % 16);
    endfunction

    function automatic logic [3:0] ref_bout(input int ai, input int bi, input int ci);
        logic [3:0] v;
        int m;
        for (int i = 0; i < 4; i++) begin
            m = 1 << (i + 1);
            v[i] = ((ai % m) < ((bi % m) + ci));
        end
        return v;
    endfunction

    function automatic logic ref_ovf(input int ai, input int bi, input int ci);
        int sa;
        int sb;
        int r;
        sa = (ai >= 8) ? ai - 16 : ai;
        sb = (bi >= 8) ? bi - 16 : bi;
        r  = sa - sb - ci;
        return (r < -8) || (r > 7);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full operation with latency, result and hold checks
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input logic ci,
                          input string tag);
        int k;
        logic [3:0] ed;
        logic [3:0] eb;
        ed = ref_d(int'(av), int'(bv), int'(ci));
        eb = ref_bout(int'(av), int'(bv), int'(ci));
        k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
        end
        start = 1'b1;
        a     = av;
        b     = bv;
        b_in  = ci;
        tick();
        start = 1'b0;
        a     = 4'($urandom);
        b     = 4'($urandom);
        b_in  = 1'($urandom);
        k = 1;
        while (!done && k < 12) begin
            tick();
            k++;
        end
        checks++;
        if (k !== 5) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected 5", tag, k);
        end
        checks++;
        if (d !== ed) begin
            errors++;
            $display("FAIL %s d: got %b, expected %b", tag, d, ed);
        end
        checks++;
        if (b_out !== eb) begin
            errors++;
            $display("FAIL %s b_out: got %b, expected %b", tag, b_out, eb);
        end
`ifdef SUB_OVF_EN
        checks++;
        if (ovf !== ref_ovf(int'(av), int'(bv), int'(ci))) begin
            errors++;
            $display("FAIL %s ovf: got %b, expected %b", tag, ovf,
                     ref_ovf(int'(av), int'(bv), int'(ci)));
        end
`endif
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || d !== ed || b_out !== eb) begin
            errors++;
            $display("FAIL %s hold: done=%b busy=%b d=%b b_out=%b, expected 0 0 %b %b",
                     tag, done, busy, d, b_out, ed, eb);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a = 4'd0; b = 4'd0; b_in = 1'b0;
        repeat (3) tick();
        checks++;
        if (d !== 4'd0 || b_out !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset state: d=%b b_out=%b busy=%b done=%b, expected all 0",
                     d, b_out, busy, done);
        end
`ifdef SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset ovf: got %b, expected 0", ovf);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_vectors();
        run_op(4'b0111, 4'b0011, 1'b0, "vec_7m3");
        run_op(4'b0011, 4'b0101, 1'b0, "vec_3m5");
        run_op(4'b1000, 4'b0001, 1'b0, "vec_8m1");
        run_op(4'b0000, 4'b0000, 1'b1, "vec_0m0b");
        run_op(4'b1111, 4'b1111, 1'b1, "vec_fmfb");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            run_op(4'($urandom), 4'($urandom), 1'($urandom), "random");
        end
    endtask

    // Start held high with other operands through the whole operation
    task automatic test_start_ignored();
        int k;
        int pulses;
        logic [3:0] ed;
        logic [3:0] eb;
        ed = ref_d(6, 9, 0);
        eb = ref_bout(6, 9, 0);
        start = 1'b1;
        a = 4'd6; b = 4'd9; b_in = 1'b0;
        tick();
        a = 4'd1; b = 4'd14; b_in = 1'b1;
        pulses = 0;
        k = 1;
        while (!done && k < 12) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL ignore busy: got %b in cycle %0d, expected 1", busy, k);
            end
            tick();
            k++;
        end
        if (done) pulses++;
        checks++;
        if (d !== ed || b_out !== eb) begin
            errors++;
            $display("FAIL ignore result: d=%b b_out=%b, expected %b %b", d, b_out, ed, eb);
        end
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 1 || k !== 5) begin
            errors++;
            $display("FAIL ignore pulses: got %0d pulses latency %0d, expected 1 and 5",
                     pulses, k);
        end
        checks++;
        if (d !== ed) begin
            errors++;
            $display("FAIL ignore hold d: got %b, expected %b", d, ed);
        end
    endtask

    // Reset sampled on the edge closing the second SHIFT cycle
    task automatic test_reset_abort();
        start = 1'b1;
        a = 4'd2; b = 4'd7; b_in = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || d !== 4'd0 || b_out !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort state: busy=%b d=%b b_out=%b done=%b, expected 0",
                     busy, d, b_out, done);
        end
`ifdef SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort ovf: got %b, expected 0", ovf);
        end
`endif
        reset = 1'b0;
        run_op(4'd5, 4'd12, 1'b0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_start_ignored();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
